// File: rtl/chip_io_pad_ring_pkg.sv
// Shared padframe constants: pad counts, analog tap range, drive-mode codes.
package chip_io_pad_ring_pkg;

    localparam int MPRJ_IO_PADS      = 38;
    localparam int ANALOG_PAD_OFFSET = 7;
    localparam int ANALOG_PADS       = 29;
    localparam int DM_WIDTH          = 3;

    typedef logic [DM_WIDTH-1:0] pad_dm_t;

    localparam pad_dm_t DM_ANALOG = 3'b000;
    localparam pad_dm_t DM_INPUT  = 3'b001;
    localparam pad_dm_t DM_STRONG = 3'b110;

    function automatic logic dm_drives(input pad_dm_t dm);
        return (dm != DM_ANALOG) && (dm != DM_INPUT);
    endfunction

endpackage

// File: rtl/chip_io_pad_ring_pad_cell.sv
// Generic bidirectional pad: tri-state driver plus gated input buffer.
// Pad readback goes through the resolved pin, so a driven pad sees itself.
module pad_cell
    import chip_io_pad_ring_pkg::*;
(
    input  logic    out,
    input  logic    oeb,
    input  logic    ieb,
    input  pad_dm_t dm,
    input  logic    porb_h,
    inout  wire     pad,
    output logic    core_in
);

    logic drive_en;

    assign drive_en = porb_h & ~oeb & dm_drives(dm);
    assign pad      = drive_en ? out : 1'bz;
    assign core_in  = ieb ? 1'b0 : pad;

endmodule

// File: rtl/chip_io_pad_ring.sv
// Padframe: package pins to management SoC and user project wrapper.
// Only state is the per-pad holdover register pair on the user I/Os.
module chip_io_pad_ring
    import chip_io_pad_ring_pkg::*;
(
    inout  wire                             vddio,
    inout  wire                             vssio,
    inout  wire                             vdda,
    inout  wire                             vssa,
    inout  wire                             vccd,
    inout  wire                             vssd,
    inout  wire                             vdda1,
    inout  wire                             vdda2,
    inout  wire                             vssa1,
    inout  wire                             vssa2,
    inout  wire                             vccd1,
    inout  wire                             vccd2,
    inout  wire                             vssd1,
    inout  wire                             vssd2,
    input  logic                            clock,
    input  logic                            por,
    input  logic                            porb_h,
    input  logic                            resetb,
    output logic                            resetb_core_h,
    output logic                            clock_core,
    inout  wire                             gpio,
    input  logic                            gpio_out_core,
    input  logic                            gpio_outenb_core,
    input  logic                            gpio_inenb_core,
    input  logic                            gpio_mode0_core,
    input  logic                            gpio_mode1_core,
    output logic                            gpio_in_core,
    output wire                             flash_csb,
    output wire                             flash_clk,
    input  logic                            flash_csb_core,
    input  logic                            flash_clk_core,
    input  logic                            flash_csb_oeb_core,
    input  logic                            flash_clk_oeb_core,
    input  logic                            flash_csb_ieb_core,
    input  logic                            flash_clk_ieb_core,
    inout  wire                             flash_io0,
    inout  wire                             flash_io1,
    input  logic                            flash_io0_do_core,
    input  logic                            flash_io0_oeb_core,
    input  logic                            flash_io0_ieb_core,
    input  logic                            flash_io1_do_core,
    input  logic                            flash_io1_oeb_core,
    input  logic                            flash_io1_ieb_core,
    output logic                            flash_io0_di_core,
    output logic                            flash_io1_di_core,
    inout  wire  [MPRJ_IO_PADS-1:0]         mprj_io,
    input  logic [MPRJ_IO_PADS-1:0]         mprj_io_out,
    input  logic [MPRJ_IO_PADS-1:0]         mprj_io_oeb,
    input  logic [MPRJ_IO_PADS-1:0]         mprj_io_inp_dis,
    input  logic [MPRJ_IO_PADS-1:0]         mprj_io_ib_mode_sel,
    input  logic [MPRJ_IO_PADS-1:0]         mprj_io_vtrip_sel,
    input  logic [MPRJ_IO_PADS-1:0]         mprj_io_slow_sel,
    input  logic [MPRJ_IO_PADS-1:0]         mprj_io_holdover,
    input  logic [MPRJ_IO_PADS-1:0]         mprj_io_analog_en,
    input  logic [MPRJ_IO_PADS-1:0]         mprj_io_analog_sel,
    input  logic [MPRJ_IO_PADS-1:0]         mprj_io_analog_pol,
    input  logic [MPRJ_IO_PADS*DM_WIDTH-1:0] mprj_io_dm,
    output logic [MPRJ_IO_PADS-1:0]         mprj_io_in,
    inout  wire  [ANALOG_PADS-1:0]          mprj_analog_io
);

    logic [MPRJ_IO_PADS-1:0] hold_out;
    logic [MPRJ_IO_PADS-1:0] hold_oeb;
    logic [MPRJ_IO_PADS-1:0] eff_out;
    logic [MPRJ_IO_PADS-1:0] eff_oeb;
    logic [MPRJ_IO_PADS-1:0] eff_ieb;
    wire  [MPRJ_IO_PADS-1:0] pad_in;
    wire                     csb_in;
    wire                     clk_in;
    wire                     gpio_in;
    wire                     io0_in;
    wire                     io1_in;

    assign clock_core    = clock;
    assign resetb_core_h = resetb;

    // Frozen bits keep their value; por forces released-driver state.
    always_ff @(posedge clock) begin
        if (por) begin
            hold_out <= '0;
            hold_oeb <= '1;
        end else begin
            hold_out <= (hold_out & mprj_io_holdover)
                      | (mprj_io_out & ~mprj_io_holdover);
            hold_oeb <= (hold_oeb & mprj_io_holdover)
                      | (mprj_io_oeb & ~mprj_io_holdover);
        end
    end

    assign eff_out = (hold_out & mprj_io_holdover)
                   | (mprj_io_out & ~mprj_io_holdover);
    assign eff_oeb = (hold_oeb & mprj_io_holdover)
                   | (mprj_io_oeb & ~mprj_io_holdover)
                   | mprj_io_analog_en;
    assign eff_ieb = mprj_io_inp_dis | mprj_io_analog_en;

    pad_cell u_gpio (
        .out     (gpio_out_core),
        .oeb     (gpio_outenb_core),
        .ieb     (gpio_inenb_core),
        .dm      ({gpio_mode1_core, gpio_mode1_core, gpio_mode0_core}),
        .porb_h  (porb_h),
        .pad     (gpio),
        .core_in (gpio_in)
    );

    pad_cell u_flash_csb (
        .out     (flash_csb_core),
        .oeb     (flash_csb_oeb_core),
        .ieb     (1'b1),
        .dm      (DM_STRONG),
        .porb_h  (porb_h),
        .pad     (flash_csb),
        .core_in (csb_in)
    );

    pad_cell u_flash_clk (
        .out     (flash_clk_core),
        .oeb     (flash_clk_oeb_core),
        .ieb     (1'b1),
        .dm      (DM_STRONG),
        .porb_h  (porb_h),
        .pad     (flash_clk),
        .core_in (clk_in)
    );

    pad_cell u_flash_io0 (
        .out     (flash_io0_do_core),
        .oeb     (flash_io0_oeb_core),
        .ieb     (flash_io0_ieb_core),
        .dm      (DM_STRONG),
        .porb_h  (porb_h),
        .pad     (flash_io0),
        .core_in (io0_in)
    );

    pad_cell u_flash_io1 (
        .out     (flash_io1_do_core),
        .oeb     (flash_io1_oeb_core),
        .ieb     (flash_io1_ieb_core),
        .dm      (DM_STRONG),
        .porb_h  (porb_h),
        .pad     (flash_io1),
        .core_in (io1_in)
    );

    assign gpio_in_core      = gpio_in;
    assign flash_io0_di_core = io0_in;
    assign flash_io1_di_core = io1_in;

    for (genvar i = 0; i < MPRJ_IO_PADS; i++) begin : g_mprj
        pad_cell u_pad (
            .out     (eff_out[i]),
            .oeb     (eff_oeb[i]),
            .ieb     (eff_ieb[i]),
            .dm      (mprj_io_dm[DM_WIDTH*i +: DM_WIDTH]),
            .porb_h  (porb_h),
            .pad     (mprj_io[i]),
            .core_in (pad_in[i])
        );
    end

    assign mprj_io_in = pad_in;

    // Rails, analog taps and electrical trims have no logical function here.
    logic unused_ok;
    assign unused_ok = ^{vddio, vssio, vdda, vssa, vccd, vssd,
                         vdda1, vdda2, vssa1, vssa2, vccd1, vccd2,
                         vssd1, vssd2, csb_in, clk_in,
                         flash_csb_ieb_core, flash_clk_ieb_core,
                         mprj_io_ib_mode_sel, mprj_io_vtrip_sel,
                         mprj_io_slow_sel, mprj_io_analog_sel,
                         mprj_io_analog_pol, mprj_analog_io};

endmodule

// File: tb/tb_chip_io_pad_ring.sv
// Bench for chip_io_pad_ring: directed pad scenarios, then random
// stimulus against a per-pad reference model of the pin rules.
module tb_chip_io_pad_ring;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    wire vddio, vssio, vdda, vssa, vccd, vssd, vdda1, vdda2;
    wire vssa1, vssa2, vccd1, vccd2, vssd1, vssd2;
    wire [28:0] ana;

    logic por, porb_h, resetb;
    logic resetb_core_h, clock_core;

    logic g_out, g_outenb, g_inenb, g_mode0, g_mode1, gpio_in_core;
    logic gpio_tb_en, gpio_tb_val;
    wire  gpio;
    assign gpio = gpio_tb_en ? gpio_tb_val : 1'bz;

    logic csb_core, fclk_core, csb_oeb, fclk_oeb, csb_ieb, fclk_ieb;
    wire  flash_csb, flash_clk;
    logic f0_do, f0_oeb, f0_ieb, f1_do, f1_oeb, f1_ieb, f0_di, f1_di;
    logic f0_tb_en, f0_tb_val, f1_tb_en, f1_tb_val;
    wire  flash_io0, flash_io1;
    assign flash_io0 = f0_tb_en ? f0_tb_val : 1'bz;
    assign flash_io1 = f1_tb_en ? f1_tb_val : 1'bz;

    logic [37:0]  m_out, m_oeb, m_dis, m_ibm, m_vt, m_slow, m_hold;
    logic [37:0]  m_aen, m_asel, m_apol, m_in;
    logic [113:0] m_dm;
    logic [37:0]  pin_en, pin_val;
    wire  [37:0]  mprj_io;

    for (genvar i = 0; i < 38; i++) begin : g_pin
        assign mprj_io[i] = pin_en[i] ? pin_val[i] : 1'bz;
    end

    chip_io_pad_ring dut (
        .vddio(vddio), .vssio(vssio), .vdda(vdda), .vssa(vssa),
        .vccd(vccd), .vssd(vssd), .vdda1(vdda1), .vdda2(vdda2),
        .vssa1(vssa1), .vssa2(vssa2), .vccd1(vccd1), .vccd2(vccd2),
        .vssd1(vssd1), .vssd2(vssd2),
        .clock(clk), .por(por), .porb_h(porb_h), .resetb(resetb),
        .resetb_core_h(resetb_core_h), .clock_core(clock_core),
        .gpio(gpio), .gpio_out_core(g_out),
        .gpio_outenb_core(g_outenb), .gpio_inenb_core(g_inenb),
        .gpio_mode0_core(g_mode0), .gpio_mode1_core(g_mode1),
        .gpio_in_core(gpio_in_core),
        .flash_csb(flash_csb), .flash_clk(flash_clk),
        .flash_csb_core(csb_core), .flash_clk_core(fclk_core),
        .flash_csb_oeb_core(csb_oeb), .flash_clk_oeb_core(fclk_oeb),
        .flash_csb_ieb_core(csb_ieb), .flash_clk_ieb_core(fclk_ieb),
        .flash_io0(flash_io0), .flash_io1(flash_io1),
        .flash_io0_do_core(f0_do), .flash_io0_oeb_core(f0_oeb),
        .flash_io0_ieb_core(f0_ieb), .flash_io1_do_core(f1_do),
        .flash_io1_oeb_core(f1_oeb), .flash_io1_ieb_core(f1_ieb),
        .flash_io0_di_core(f0_di), .flash_io1_di_core(f1_di),
        .mprj_io(mprj_io), .mprj_io_out(m_out), .mprj_io_oeb(m_oeb),
        .mprj_io_inp_dis(m_dis), .mprj_io_ib_mode_sel(m_ibm),
        .mprj_io_vtrip_sel(m_vt), .mprj_io_slow_sel(m_slow),
        .mprj_io_holdover(m_hold), .mprj_io_analog_en(m_aen),
        .mprj_io_analog_sel(m_asel), .mprj_io_analog_pol(m_apol),
        .mprj_io_dm(m_dm), .mprj_io_in(m_in),
        .mprj_analog_io(ana)
    );

    // Reference holdover state: last value sampled while not held.
    logic [37:0] r_hout, r_hoeb;
    always @(posedge clk) begin
        for (int i = 0; i < 38; i++) begin
            if (por) begin
                r_hout[i] <= 1'b0;
                r_hoeb[i] <= 1'b1;
            end else if (!m_hold[i]) begin
                r_hout[i] <= m_out[i];
                r_hoeb[i] <= m_oeb[i];
            end
        end
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [37:0] got,
                       input logic [37:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic drives(input logic pb, input logic oeb,
                                    input int dm);
        return pb && !oeb && (dm >= 2);
    endfunction

    function automatic logic [37:0] rand38();
        logic [63:0] r;
        r = {$urandom, $urandom};
        return r[37:0];
    endfunction

    function automatic logic rbit();
        return 1'($urandom_range(1, 0));
    endfunction

    task automatic check_all(input string tag);
        logic [37:0] drv, exp_pin, exp_in;
        logic eo, eb, g_drv, f0_drv, f1_drv, exp_g, exp_f0, exp_f1;
        @(negedge clk);
        for (int i = 0; i < 38; i++) begin
            eo = m_hold[i] ? r_hout[i] : m_out[i];
            eb = m_hold[i] ? r_hoeb[i] : m_oeb[i];
            drv[i] = drives(porb_h, eb | m_aen[i], int'(m_dm[3*i +: 3]));
            exp_pin[i] = drv[i] ? eo : pin_val[i];
            exp_in[i] = (m_dis[i] | m_aen[i]) ? 1'b0 : exp_pin[i];
        end
        pin_en = ~drv;
        g_drv = drives(porb_h, g_outenb, int'({g_mode1, g_mode1, g_mode0}));
        f0_drv = drives(porb_h, f0_oeb, 6);
        f1_drv = drives(porb_h, f1_oeb, 6);
        gpio_tb_en = ~g_drv;
        f0_tb_en = ~f0_drv;
        f1_tb_en = ~f1_drv;
        exp_g = g_drv ? g_out : gpio_tb_val;
        exp_f0 = f0_drv ? f0_do : f0_tb_val;
        exp_f1 = f1_drv ? f1_do : f1_tb_val;
        #1;
        chk({tag, ":mprj_io"}, mprj_io, exp_pin);
        chk({tag, ":mprj_in"}, m_in, exp_in);
        chk({tag, ":gpio"}, 38'(gpio), 38'(exp_g));
        chk({tag, ":gpio_in"}, 38'(gpio_in_core),
            38'(g_inenb ? 1'b0 : exp_g));
        chk({tag, ":io0"}, 38'(flash_io0), 38'(exp_f0));
        chk({tag, ":io0_di"}, 38'(f0_di), 38'(f0_ieb ? 1'b0 : exp_f0));
        chk({tag, ":io1"}, 38'(flash_io1), 38'(exp_f1));
        chk({tag, ":io1_di"}, 38'(f1_di), 38'(f1_ieb ? 1'b0 : exp_f1));
        if (porb_h && !csb_oeb)
            chk({tag, ":csb"}, 38'(flash_csb), 38'(csb_core));
        if (porb_h && !fclk_oeb)
            chk({tag, ":fclk"}, 38'(flash_clk), 38'(fclk_core));
    endtask

    initial begin
        por = 1'b1; porb_h = 1'b1; resetb = 1'b0;
        g_out = 0; g_outenb = 1; g_inenb = 1; g_mode0 = 0; g_mode1 = 0;
        gpio_tb_en = 0; gpio_tb_val = 0;
        csb_core = 0; fclk_core = 0; csb_oeb = 1; fclk_oeb = 1;
        csb_ieb = 1; fclk_ieb = 1;
        f0_do = 0; f0_oeb = 1; f0_ieb = 1; f0_tb_en = 0; f0_tb_val = 0;
        f1_do = 0; f1_oeb = 1; f1_ieb = 1; f1_tb_en = 0; f1_tb_val = 0;
        m_out = '1; m_oeb = '0; m_dis = '0; m_ibm = '0; m_vt = '0;
        m_slow = '0; m_hold = '1; m_aen = '0; m_asel = '0; m_apol = '0;
        m_dm = {38{3'b110}};
        pin_en = '0; pin_val = '0;

        // Reset while held: every user pad must be released.
        check_all("por_hiz");
        chk("resetb_lo", 38'(resetb_core_h), 38'(1'b0));
        por = 1'b0; resetb = 1'b1;
        #1 chk("resetb_hi", 38'(resetb_core_h), 38'(1'b1));
        chk("clk_lo", 38'(clock_core), 38'(clk));
        @(posedge clk);
        #1 chk("clk_hi", 38'(clock_core), 38'(clk));

        gpio_tb_val = 1; g_inenb = 0; g_outenb = 1; g_mode1 = 0; g_mode0 = 1;
        check_all("gpio_in");
        gpio_tb_val = 0; g_out = 1; g_outenb = 0; g_mode1 = 1; g_mode0 = 0;
        check_all("gpio_out");

        csb_core = 1; fclk_core = 1; csb_oeb = 0; fclk_oeb = 0;
        f0_tb_val = 1; f0_ieb = 0; f0_oeb = 1;
        check_all("flash_in");
        f0_tb_val = 0; f0_do = 1; f0_oeb = 0;
        check_all("flash_out");

        m_hold = '0; m_out = 38'h15_0000F0F0; m_oeb = '0;
        check_all("mprj_out");
        m_oeb = '1; m_dm = {38{3'b001}}; pin_val = 38'h0A_0000FF0F;
        check_all("mprj_in");
        m_dis = '1;
        check_all("mprj_dis");

        m_dis = '0; m_dm = {38{3'b110}}; m_oeb = '0; m_out = '1;
        pin_val = '0;
        check_all("hold_cap");
        m_hold[0] = 1'b1; m_out[0] = 1'b0;
        check_all("hold_keep");
        por = 1'b1;
        check_all("hold_por");
        por = 1'b0;
        m_hold[0] = 1'b0; m_out[0] = 1'b1;
        check_all("hold_rel");

        porb_h = 1'b0; m_out = '1; pin_val = '0;
        g_out = 1; gpio_tb_val = 0; f0_do = 1; f0_tb_val = 0;
        f1_do = 1; f1_oeb = 0; f1_tb_val = 0;
        check_all("porb_off");
        porb_h = 1'b1; m_aen = 38'h20;
        check_all("analog5");
        m_aen = '0;

        for (int it = 0; it < 400; it++) begin
            m_out = rand38(); m_oeb = rand38() & rand38();
            m_dis = rand38() & rand38();
            m_aen = rand38() & rand38() & rand38();
            m_hold = m_hold ^ (rand38() & rand38() & rand38());
            m_ibm = rand38(); m_vt = rand38(); m_slow = rand38();
            m_asel = rand38(); m_apol = rand38();
            for (int i = 0; i < 38; i++)
                m_dm[3*i +: 3] = 3'($urandom_range(7, 0));
            pin_val = rand38();
            por = ($urandom_range(15, 0) == 0);
            porb_h = ($urandom_range(9, 0) != 0);
            g_out = rbit(); g_outenb = rbit(); g_inenb = rbit();
            g_mode0 = rbit(); g_mode1 = rbit(); gpio_tb_val = rbit();
            csb_core = rbit(); fclk_core = rbit();
            csb_oeb = rbit(); fclk_oeb = rbit();
            csb_ieb = rbit(); fclk_ieb = rbit();
            f0_do = rbit(); f0_oeb = rbit(); f0_ieb = rbit();
            f1_do = rbit(); f1_oeb = rbit(); f1_ieb = rbit();
            f0_tb_val = rbit(); f1_tb_val = rbit();
            check_all("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
